// File: rtl/simple_bus_arbiter.sv
// Two-master round-robin arbiter feeding one simple-bus slave; one transaction in flight.
// Latency: grant at edge E, bus request in cycle E+1, response pulse in E+2 with a ready slave.
// Backpressure: masters stall via req_ready; slave stalls via simple_out_ready until timeout; responses cannot stall.
`timescale 1ns/1ps
module simple_bus_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clock,
   input  logic              reset,
   // master 0 (instruction fetch)
   input  logic              m0_req_valid,
   output logic              m0_req_ready,
   input  logic [ADDR_W-1:0] m0_req_addr,
   input  logic              m0_req_writeEn,
   input  logic [2:0]        m0_req_size,
   input  logic [DATA_W-1:0] m0_req_wdata,
   output logic              m0_resp_valid,
   output logic [DATA_W-1:0] m0_resp_rdata,
   output logic              m0_resp_err,
   // master 1 (load/store)
   input  logic              m1_req_valid,
   output logic              m1_req_ready,
   input  logic [ADDR_W-1:0] m1_req_addr,
   input  logic              m1_req_writeEn,
   input  logic [2:0]        m1_req_size,
   input  logic [DATA_W-1:0] m1_req_wdata,
   output logic              m1_resp_valid,
   output logic [DATA_W-1:0] m1_resp_rdata,
   output logic              m1_resp_err,
   // slave side
   output logic              simple_out_valid,
   input  logic              simple_out_ready,
   output logic [ADDR_W-1:0] simple_out_bits_addr,
   output logic              simple_out_bits_writeEn,
   output logic [2:0]        simple_out_bits_size,
   output logic [DATA_W-1:0] simple_out_bits_wdata,
   input  logic [DATA_W-1:0] simple_in_rdata
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                last_grant_q, last_grant_d;
   logic                grant_q, grant_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [2:0]          size_q, size_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;

   logic                arb_vld;
   logic                arb_id;

   // Round-robin pick: a lone requester wins, contention goes to the master not served last.
   always_comb begin
      arb_vld = m0_req_valid | m1_req_valid;
      arb_id  = 1'b0;
      if (m0_req_valid && m1_req_valid) begin
         arb_id = ~last_grant_q;
      end else if (m1_req_valid) begin
         arb_id = 1'b1;
      end
   end

   // Next-state: grant and latch in IDLE, wait for slave or timeout in ISSUE, one-cycle RESP.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      err_d        = err_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      we_d         = we_q;
      size_d       = size_q;
      wdata_d      = wdata_q;
      case (state_q)
         IDLE: begin
            if (arb_vld) begin
               addr_d       = arb_id ? m1_req_addr    : m0_req_addr;
               we_d         = arb_id ? m1_req_writeEn : m0_req_writeEn;
               size_d       = arb_id ? m1_req_size    : m0_req_size;
               wdata_d      = arb_id ? m1_req_wdata   : m0_req_wdata;
               grant_d      = arb_id;
               last_grant_d = arb_id;
               cnt_d        = '0;
               err_d        = 1'b0;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            if (simple_out_ready) begin
               state_d = RESP;
            end else if (cnt_q == CNT_LAST) begin
               // Slave never answered: give up and return an error response.
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and latched-request registers; reset abandons any transaction in flight.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         err_q        <= 1'b0;
         cnt_q        <= '0;
         addr_q       <= '0;
         we_q         <= 1'b0;
         size_q       <= '0;
         wdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         size_q       <= size_d;
         wdata_q      <= wdata_d;
      end
   end

   // Output decode; req_ready is gated by reset because IDLE is also the reset state.
   always_comb begin
      m0_req_ready            = 1'b0;
      m1_req_ready            = 1'b0;
      m0_resp_valid           = 1'b0;
      m1_resp_valid           = 1'b0;
      m0_resp_rdata           = '0;
      m1_resp_rdata           = '0;
      m0_resp_err             = 1'b0;
      m1_resp_err             = 1'b0;
      simple_out_valid        = (state_q == ISSUE);
      simple_out_bits_addr    = addr_q;
      simple_out_bits_writeEn = we_q;
      simple_out_bits_size    = size_q;
      simple_out_bits_wdata   = wdata_q;
      if (reset && state_q == IDLE && arb_vld) begin
         m0_req_ready = ~arb_id & m0_req_valid;
         m1_req_ready =  arb_id & m1_req_valid;
      end
      if (state_q == RESP) begin
         if (grant_q) begin
            m1_resp_valid = 1'b1;
            m1_resp_err   = err_q;
            m1_resp_rdata = err_q ? '0 : simple_in_rdata;
         end else begin
            m0_resp_valid = 1'b1;
            m0_resp_err   = err_q;
            m0_resp_rdata = err_q ? '0 : simple_in_rdata;
         end
      end
   end

endmodule
